// File: rtl/psum_accum_sat_if.sv
// rtl/psum_accum_sat_if.sv - beat input and result output handshake bundle
interface psum_accum_sat_if #(
  parameter int DATA_W = 12,
  parameter int NCH    = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NCH*DATA_W-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [NCH*DATA_W-1:0] out_data;
  logic [NCH-1:0]        out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/psum_accum_sat.sv
// rtl/psum_accum_sat.sv - multi-lane saturating window accumulator
// Each lane saturates on every beat; completed windows land in a one-deep output register.
module psum_accum_sat #(
  parameter int DATA_W = 12,
  parameter int NCH    = 4,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             acc_clr,
  psum_accum_sat_if.slave  bus
);
  localparam int W = NCH * DATA_W;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d, out_data_q, out_data_d, acc_base, sum_sat;
  logic [NCH-1:0]   flags_q, flags_d, out_sat_q, out_sat_d, flags_base, clamp;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_base, eff_len, cur_len;
  logic             out_valid, in_ready, accept, consume, win_end;

  assign out_valid = (state_q == FULL);
  assign in_ready  = ~rst & (~out_valid | bus.out_ready);
  assign accept    = bus.in_valid & in_ready;
  assign consume   = out_valid & bus.out_ready;

  // acc_clr folds into the operands so a coincident beat starts a fresh window
  assign acc_base   = acc_clr ? '0 : acc_q;
  assign flags_base = acc_clr ? '0 : flags_q;
  assign cnt_base   = acc_clr ? '0 : cnt_q;
  assign eff_len    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign cur_len    = (cnt_base == '0) ? eff_len : len_q;
  assign win_end    = accept & (cnt_base == cur_len - LEN_W'(1));

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic [DATA_W-1:0] a, b;
    logic [DATA_W:0]   s;
    assign a = acc_base[k*DATA_W +: DATA_W];
    assign b = bus.in_data[k*DATA_W +: DATA_W];
    assign s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    assign clamp[k] = s[DATA_W] ^ s[DATA_W-1];
    assign sum_sat[k*DATA_W +: DATA_W] = !clamp[k] ? s[DATA_W-1:0] :
                                         (s[DATA_W] ? SAT_MIN : SAT_MAX);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_base;
    flags_d    = flags_base;
    cnt_d      = cnt_base;
    len_d      = len_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (accept) begin
      len_d = cur_len;
      if (win_end) begin
        acc_d      = '0;
        flags_d    = '0;
        cnt_d      = '0;
        out_data_d = sum_sat;
        out_sat_d  = flags_base | clamp;
      end else begin
        acc_d   = sum_sat;
        flags_d = flags_base | clamp;
        cnt_d   = cnt_base + LEN_W'(1);
      end
    end
    case (state_q)
      EMPTY:   if (win_end) state_d = FULL;
      FULL:    if (consume && !win_end) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      acc_q      <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
      len_q      <= LEN_W'(1);
      out_data_q <= '0;
      out_sat_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: doc/psum_accum_sat.md
# psum_accum_sat

Parametrised multi-lane saturating partial-sum accumulator for the PE/psum datapath. Each lane adds a stream of signed fixed-point psums into a per-lane accumulator, with per-beat saturation and a programmable window length. At the end of each window the block emits one saturated sum per lane, plus per-lane saturation flags, through a single-entry valid/ready output register. It generalises the single-cycle two-operand saturating adder to N lanes, configurable width and multi-beat accumulation with flow control.

## Interface
Parameters:
- DATA_W, 12: psum width, signed two's complement fixed point (default (12,5); the binary point does not affect arithmetic).
- NCH, 4: number of independent lanes.
- LEN_W, 8: width of the window-length field.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_len  in  LEN_W  beats per accumulation window; 0 treated as 1.
- acc_clr  in  1  synchronous pulse; discards the partial window.
- in_valid  in  1  input beat valid (all lanes together).
- in_ready  out  1  block can accept a beat.
- in_data  in  NCH*DATA_W  lane k = bits [k*DATA_W +: DATA_W].
- out_valid  out  1  result register holds a completed window.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NCH*DATA_W  saturated window sums, same lane packing.
- out_sat  out  NCH  per-lane flag: saturation occurred at least once in the window.

## Operation
- A beat is accepted when in_valid & in_ready. The output is consumed when out_valid & out_ready.
- in_ready = ~rst & (~out_valid | out_ready). This is combinational; a beat may be accepted in the same cycle the result drains.
- Per-lane arithmetic on each accepted beat:
  - s = sext(acc) + sext(in), computed at DATA_W+1 bits.
  - Positive overflow: s[DATA_W] = 0 and s[DATA_W-1] = 1. Clamp to 2^(DATA_W-1)-1 (0x7FF at default).
  - Negative overflow: s[DATA_W] = 1 and s[DATA_W-1] = 0. Clamp to -2^(DATA_W-1) (0x800 at default).
  - Otherwise the result is s[DATA_W-1:0].
  - Saturation is applied every beat, not only at window end. The order of inputs therefore matters.
  - The lane's sticky flag is set on any clamp.
- Beat counter cnt (LEN_W bits):
  - The window length len_q is latched from cfg_len (0 becomes 1) on the first beat of each window (cnt = 0).
  - Changes to cfg_len mid-window are ignored.
- Window end: the accepted beat with cnt = len_q-1.
  - The saturated sums and flags (including this beat's contribution) load into out_data/out_sat, and out_valid is set.
  - acc, flags and cnt return to 0 in the same edge.
- State machine:
  - EMPTY (out_valid = 0) goes to FULL on a window-end beat.
  - FULL goes to EMPTY on consume with no window-end beat in the same cycle.
  - FULL stays FULL on consume together with a window-end beat; the register reloads back-to-back.
  - FULL with ~out_ready holds out_data/out_sat stable and in_ready = 0.
- acc_clr:
  - Zeros acc, flags and cnt. The output register is unaffected.
  - If it coincides with an accepted beat, the beat becomes beat 0 of a fresh window: acc = in, and len_q is relatched.
  - If that beat also ends the window (len_q = 1), it completes normally.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sat = 0, in_ready = 0 while rst is high, and 1 the cycle after release.
- Internal reset values: acc = 0, cnt = 0, flags = 0, len_q = 1.
- Latency: the window-end beat accepted at edge N gives out_valid = 1 after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained when out_ready = 1. len_q = 1 gives one result per cycle.
- Reset asserted mid-window or while FULL: all state clears immediately; the partial window and the undrained result are lost.

## Test plan
- Basic sum (DATA_W = 12, cfg_len = 3, out_ready = 1):
  - Lane 0 inputs 0x100, 0x200, 0x050 -> out_data lane 0 = 0x350, out_sat = 0.
  - out_valid is high for one cycle, one cycle after the third beat.
- Per-beat saturation (cfg_len = 3):
  - Lane 1 inputs 0x700, 0x200, 0xF00 -> 0x7FF after beat 2, final 0x6FF, out_sat[1] = 1.
  - Lane 2 inputs 0x900, 0x900, 0x000 -> 0x800, out_sat[2] = 1.
- Backpressure (cfg_len = 1, out_ready held low 4 cycles):
  - in_ready = 0 while FULL; out_data stays stable; no beats are lost.
  - On release, consume and accept happen in the same cycle and out_valid stays high.
- Clear mid-window (cfg_len = 4):
  - 2 beats of 0x010, then acc_clr together with a beat of 0x020, then 3 beats of 0x001 -> result 0x023.
  - Exactly one result is produced.
- cfg_len edge cases:
  - cfg_len = 0 behaves as 1.
  - Changing cfg_len 4 -> 2 after beat 1 of a window: that window still spans 4 beats; the next window spans 2.
- Reset:
  - Assert rst after 2 of 3 beats while a prior result is pending -> out_valid = 0 and out_data = 0 immediately.
  - A following 3-beat window sums from 0.
